echip65_sample_fifo: RTL and testbench

ECHIP65_SAMPLE_FIFO -- requirements
Module: echip65_sample_fifo

---
 rtl/echip65_sample_fifo.sv | 136 +++++++++++++
 tb/tb_echip65_sample_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/echip65_sample_fifo.sv
// Purpose: capture decimated CIC words, round/saturate to OUT_WIDTH and buffer them for a reader.
// Latency: sample lands in the FIFO 2 clk edges after divided_clk rises; rd_data valid 1 edge after rd_en.
// Backpressure: none upstream; a capture into a full FIFO is dropped (sticky overflow) unless a read frees a slot that same edge.
//
// Ports:
//   clk, reset_n            modulator clock, asynchronous active-low reset
//   cic_out [NUMBITS]       unsigned decimated CIC word
//   divided_clk             CIC decimation clock; its rising edge (resynchronised) triggers a capture
//   en                      capture enable (reads are unaffected)
//   rd_en                   pop request; ignored while empty
//   ovf_clr                 clears the sticky overflow flag (a same-cycle drop wins)
//   rd_data [OUT_WIDTH]     registered read data, held between reads
//   empty, full, count      occupancy status, decoded from the registered count
//   overflow                sticky: at least one captured sample was dropped
//   sample_cnt [16]         number of accepted captures, free-running wrap
module echip65_sample_fifo #(
  parameter int NUMBITS   = 25,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUMBITS-1:0]         cic_out,
  input  logic                       divided_clk,
  input  logic                       en,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  output logic [OUT_WIDTH-1:0]       rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                sample_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int SHIFT = NUMBITS - 1 - OUT_WIDTH;

  // Largest positive value of the CIC word; anything above it is clipped.
  localparam logic [NUMBITS-1:0] SAT_MAX = {1'b0, {(NUMBITS-1){1'b1}}};
  // Half an output LSB, so the right shift rounds to nearest.
  localparam logic [NUMBITS:0]   RND     = (NUMBITS+1)'(1) << (SHIFT - 1);

  logic                 r_div_q;
  logic                 r_div_q_d;
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;
  logic [15:0]          r_sample_cnt;
  logic [OUT_WIDTH-1:0] r_rd_data;
  logic [OUT_WIDTH-1:0] r_mem [DEPTH];

  logic                 w_cap;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_drop;
  logic [NUMBITS-1:0]   w_sat;
  logic [NUMBITS:0]     w_sum;
  logic [NUMBITS:0]     w_shifted;
  logic [OUT_WIDTH-1:0] w_word;

  // Rising edge of the resynchronised decimation clock; en gates only the capture.
  assign w_cap = r_div_q & ~r_div_q_d & en;

  // Saturate, round, shift; rounding can carry past OUT_WIDTH so clip again.
  assign w_sat     = (cic_out > SAT_MAX) ? SAT_MAX : cic_out;
  assign w_sum     = {1'b0, w_sat} + RND;
  assign w_shifted = w_sum >> SHIFT;
  assign w_word    = (|w_shifted[NUMBITS:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                     : w_shifted[OUT_WIDTH-1:0];

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A read on the same edge as a capture into a full FIFO frees the slot the write needs.
  assign w_rd    = rd_en & ~w_empty;
  assign w_wr    = w_cap & (~w_full | w_rd);
  assign w_drop  = w_cap & w_full & ~rd_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_q      <= 1'b0;
      r_div_q_d    <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_sample_cnt <= '0;
      r_rd_data    <= '0;
    end else begin
      r_div_q   <= divided_clk;
      r_div_q_d <= r_div_q;

      if (w_wr) begin
        r_wptr       <= r_wptr + AW'(1);
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end

      if (w_rd) begin
        r_rptr    <= r_rptr + AW'(1);
        r_rd_data <= r_mem[r_rptr];
      end

      if (w_wr && !w_rd) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - CW'(1);
      end

      // Drop takes priority over a same-cycle clear so no loss goes unreported.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable through the pointers.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  assign rd_data    = r_rd_data;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_echip65_sample_fifo.sv
module tb_echip65_sample_fifo;

  logic        clk;
  logic        reset_n;
  logic [24:0] cic_out;
  logic        divided_clk;
  logic        en;
  logic        rd_en;
  logic        ovf_clr;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  echip65_sample_fifo #(.NUMBITS(25), .OUT_WIDTH(16), .DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cic_out     (cic_out),
    .divided_clk (divided_clk),
    .en          (en),
    .rd_en       (rd_en),
    .ovf_clr     (ovf_clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .sample_cnt  (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One decimation period: divided_clk high for two edges (capture on the second), then low for two.
  task automatic capture(input logic [24:0] v, input logic rd, input logic clr);
    cic_out     = v;
    divided_clk = 1'b1;
    tick();
    rd_en   = rd;
    ovf_clr = clr;
    tick();
    rd_en       = 1'b0;
    ovf_clr     = 1'b0;
    divided_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic read1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    logic [24:0] v;

    reset_n     = 1'b0;
    cic_out     = '0;
    divided_clk = 1'b0;
    en          = 1'b1;
    rd_en       = 1'b0;
    ovf_clr     = 1'b0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_scnt", 32'(sample_cnt), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Full-scale input saturates to 2^24-1, rounds to 65536, clips to 0xFFFF.
    capture(25'h1000000, 1'b0, 1'b0);
    chk("sat_count", 32'(count), 32'd1);
    chk("sat_scnt", 32'(sample_cnt), 32'd1);
    chk("sat_empty", 32'(empty), 32'd0);
    read1();
    chk("sat_rdata", 32'(rd_data), 32'hFFFF);
    chk("sat_empty_after", 32'(empty), 32'd1);

    // Rounding boundary: 0x180 -> 2, 0x17F -> 1.
    capture(25'h000180, 1'b0, 1'b0);
    capture(25'h00017F, 1'b0, 1'b0);
    chk("rnd_count", 32'(count), 32'd2);
    read1();
    chk("rnd_up", 32'(rd_data), 32'h0002);
    read1();
    chk("rnd_down", 32'(rd_data), 32'h0001);

    // Read while empty: data held, no pointer or count change.
    read1();
    chk("rdempty_hold", 32'(rd_data), 32'h0001);
    chk("rdempty_count", 32'(count), 32'd0);

    // Capture disabled.
    en = 1'b0;
    capture(25'h005500, 1'b0, 1'b0);
    en = 1'b1;
    chk("en0_count", 32'(count), 32'd0);
    chk("en0_scnt", 32'(sample_cnt), 32'd3);

    // Nine captures, no reads: the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      v = 25'((16 + i) * 256);
      capture(v, 1'b0, 1'b0);
      if (i == 7) begin
        chk("fill_full8", 32'(full), 32'd1);
        chk("fill_ovf8", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_scnt", 32'(sample_cnt), 32'd11);
    for (int i = 0; i < 8; i++) begin
      read1();
      chk("drain_order", 32'(rd_data), 32'(16 + i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO with a read on the capture edge: both happen.
    for (int i = 0; i < 8; i++) begin
      v = 25'((32 + i) * 256);
      capture(v, 1'b0, 1'b0);
    end
    chk("rw_pre_full", 32'(full), 32'd1);
    capture(25'((32 + 8) * 256), 1'b1, 1'b0);
    chk("rw_count", 32'(count), 32'd8);
    chk("rw_ovf", 32'(overflow), 32'd0);
    chk("rw_rdata", 32'(rd_data), 32'h0020);
    chk("rw_scnt", 32'(sample_cnt), 32'd20);
    for (int i = 0; i < 8; i++) begin
      read1();
      chk("rw_drain", 32'(rd_data), 32'(33 + i));
    end
    chk("rw_empty", 32'(empty), 32'd1);

    // Drop and clear in the same cycle: set wins; then clear alone.
    for (int i = 0; i < 8; i++) begin
      v = 25'((48 + i) * 256);
      capture(v, 1'b0, 1'b0);
    end
    capture(25'h003800, 1'b0, 1'b1);
    chk("dropclr_ovf", 32'(overflow), 32'd1);
    chk("dropclr_count", 32'(count), 32'd8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clronly_ovf", 32'(overflow), 32'd0);
    capture(25'h003900, 1'b0, 1'b0);
    chk("drop2_ovf", 32'(overflow), 32'd1);
    chk("drop2_scnt", 32'(sample_cnt), 32'd28);
    read1();
    chk("mid_rd0", 32'(rd_data), 32'h0030);
    read1();
    read1();
    chk("mid_rd2", 32'(rd_data), 32'h0032);
    chk("mid_count5", 32'(count), 32'd5);

    // Asynchronous reset mid-stream, checked before any clk edge.
    reset_n = 1'b0;
    #2;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_rdata", 32'(rd_data), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_scnt", 32'(sample_cnt), 32'd0);
    reset_n = 1'b1;
    tick();

    // Read and write together on an empty FIFO: write only.
    capture(25'h000300, 1'b1, 1'b0);
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_rdata", 32'(rd_data), 32'd0);
    chk("emptyrw_scnt", 32'(sample_cnt), 32'd1);
    read1();
    chk("emptyrw_read", 32'(rd_data), 32'h0003);
    chk("emptyrw_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
